store_align_unit: RTL and testbench
===================================

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 SHALL have parameter MISALIGN_SPLIT, default 1, meaning 1 = split word-crossing stores into two beats, 0 = reject them with err.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit can accept a request.
- req_addr  in  32  byte address.
- req_data  in  32  store data, right-justified (rs2).
- req_size  in  2  00 = SB, 01 = SH, 10 = SW, 11 = illegal.
- mem_valid  out  1  memory write beat valid.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  32  word-aligned beat address.
- mem_wdata  out  32  lane-placed write data.
- mem_wstrb  out  4  byte-lane write strobes.
- done  out  1  one-cycle pulse, request retired.
- err  out  1  one-cycle pulse with done, request rejected.

Function
REQ-004 SHALL use FSM states IDLE, BEAT0, BEAT1, FIN.
REQ-005 In IDLE, req_ready SHALL be 1; all other states SHALL drive req_ready 0.
REQ-006 A request is accepted on the clk edge where req_valid && req_ready; addr, data and size SHALL be captured in that cycle.
REQ-007 Lane generation SHALL work as follows:
- off = addr[1:0].
- base mask = 0001/0011/1111 for size 00/01/10.
- m8 = base << off (8 bits).
- d64 = (data with unused upper bytes zeroed) << 8*off.
- Beat 0 = {addr & ~3, d64[31:0], m8[3:0]}.
- Beat 1 = {(addr & ~3) + 4, d64[63:32], m8[7:4]}; beat 1 exists only when m8[7:4] != 0.
REQ-008 Beat-1 address SHALL wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000).
REQ-009 After acceptance of a legal request, the unit SHALL enter BEAT0 and assert mem_valid with beat-0 fields on the next cycle.
REQ-010 mem_valid, mem_addr, mem_wdata and mem_wstrb SHALL remain stable while mem_valid && !mem_ready.
REQ-011 A beat completes on the edge where mem_valid && mem_ready; mem_valid SHALL NOT be withdrawn before completion.
REQ-012 After beat 0 completes, the unit SHALL go to BEAT1 if beat 1 exists, otherwise to FIN; after beat 1 completes, it SHALL go to FIN.
REQ-013 In FIN, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-014 With mem_ready held 1, latency SHALL be: aligned request accepted at cycle 0, mem_valid at cycle 1, done at cycle 2; a split request gives done at cycle 3.
REQ-015 When mem_valid is 0, mem_wdata and mem_wstrb SHALL be 0; mem_wdata bytes whose strobe is 0 SHALL be 0.
REQ-016 req_size = 11 SHALL issue no beat; the FSM SHALL go to FIN directly, with done = 1 and err = 1 on the next cycle.
REQ-017 With MISALIGN_SPLIT = 0, a request with m8[7:4] != 0 SHALL issue no beat and SHALL behave as REQ-016.
REQ-018 A misaligned request whose m8[7:4] = 0 (e.g. SH at off 1) SHALL be a single legal beat in both modes.
REQ-019 err SHALL be 0 whenever done is 0.
REQ-020 mem_ready while mem_valid = 0 SHALL be ignored.

Reset
REQ-021 While rst = 1 at a clk edge: state SHALL become IDLE, and mem_valid, done, err, mem_addr, mem_wdata and mem_wstrb SHALL be 0; req_ready SHALL be 0 during the rst cycle.
REQ-022 rst asserted mid-transaction SHALL abandon the request without done, with no further beat issued after the reset edge.

Structure
REQ-023 Shared package rv32_lsu_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W) and the FSM state enum.
REQ-024 Lane generation (REQ-007) SHALL be a separate combinational sub-module store_lane_gen; the FSM, capture registers and handshake SHALL live in store_align_unit.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- SW addr 0x00001000, data 0xDEADBEEF, mem_ready = 1 -> one beat: addr 0x00001000, wdata 0xDEADBEEF, wstrb 1111; done at cycle 2; err 0.
- SB addr 0x00000003, data 0x123456A5 -> one beat: addr 0x00000000, wdata 0xA5000000, wstrb 1000.
- SW addr 0x00000006, data 0x11223344, MISALIGN_SPLIT = 1 -> beat 0: addr 0x00000004, wdata 0x33440000, wstrb 1100; beat 1: addr 0x00000008, wdata 0x00001122, wstrb 0011; done at cycle 3.
- SH addr 0xFFFFFFFF, data 0x0000BEEF -> beat 0: addr 0xFFFFFFFC, wstrb 1000, wdata 0xEF000000; beat 1: addr 0x00000000, wstrb 0001, wdata 0x000000BE.
- mem_ready held 0 for 3 cycles on an SW -> beat fields stable for 4 cycles; done one cycle after mem_ready = 1; then size 11 -> done = 1 and err = 1, with no mem_valid.
- rst pulsed during beat 1 of a split SW -> mem_valid 0 after the reset edge, no done; the next request proceeds normally.

Source files
------------

// File: rtl/rv32_lsu_pkg.sv
// rv32_lsu_pkg: shared store size encodings and store FSM state type.
package rv32_lsu_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FIN} state_t;
endpackage

// File: rtl/store_lane_gen.sv
// store_lane_gen: places a right-justified store into one or two word beats.
// Ports: addr/data/size in; addr0/wdata0/strb0 and addr1/wdata1/strb1 beat fields out;
// split out when the store crosses into the next word.
module store_lane_gen
    import rv32_lsu_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    output logic [31:0] addr0,
    output logic [31:0] addr1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [3:0]  strb0,
    output logic [3:0]  strb1,
    output logic        split
);
    logic [3:0]  base;
    logic [31:0] dm;
    logic [7:0]  m8;
    logic [63:0] d64;
    always_comb begin
        base   = size == SZ_B ? 4'b0001 : size == SZ_H ? 4'b0011 : size == SZ_W ? 4'b1111 : 4'b0000;
        dm     = size == SZ_B ? {24'b0, data[7:0]} : size == SZ_H ? {16'b0, data[15:0]} : data;
        m8     = {4'b0, base} << addr[1:0];
        d64    = {32'b0, dm} << {addr[1:0], 3'b000};
        addr0  = addr & ~32'd3;
        addr1  = addr0 + 32'd4;
        wdata0 = d64[31:0];
        wdata1 = d64[63:32];
        strb0  = m8[3:0];
        strb1  = m8[7:4];
        split  = |m8[7:4];
    end
endmodule

// File: rtl/store_align_unit.sv
// store_align_unit: accepts one store, issues its aligned write beat(s), pulses done/err.
// Ports: clk/rst; req_valid/req_ready/req_addr/req_data/req_size request side;
// mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb beat side; done/err retire pulses.
module store_align_unit
    import rv32_lsu_pkg::*;
#(
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        done,
    output logic        err
);
    state_t      state, next;
    logic [31:0] addr_q, data_q, addr0, addr1, wdata0, wdata1;
    logic [1:0]  size_q;
    logic [3:0]  strb0, strb1;
    logic        err_q, split, idle, bad, b1;
    // In IDLE the lane generator looks at the live request so the accept
    // edge can already decide between issuing beats and rejecting.
    assign idle = state == IDLE;
    store_lane_gen u_lane (
        .addr   (idle ? req_addr : addr_q),
        .data   (idle ? req_data : data_q),
        .size   (idle ? req_size : size_q),
        .addr0  (addr0),
        .addr1  (addr1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .strb0  (strb0),
        .strb1  (strb1),
        .split  (split)
    );
    assign bad = req_size == 2'b11 || (MISALIGN_SPLIT == 0 && split);
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            size_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= next;
            if (req_valid && req_ready) begin
                addr_q <= req_addr;
                data_q <= req_data;
                size_q <= req_size;
                err_q  <= bad;
            end
        end
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:  next = req_valid ? (bad ? FIN : BEAT0) : IDLE;
            BEAT0: next = mem_ready ? (split ? BEAT1 : FIN) : BEAT0;
            BEAT1: next = mem_ready ? FIN : BEAT1;
            FIN:   next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        req_ready = !rst && idle;
        mem_valid = !rst && (state == BEAT0 || state == BEAT1);
        b1        = state == BEAT1;
        mem_addr  = mem_valid ? (b1 ? addr1 : addr0) : '0;
        mem_wdata = mem_valid ? (b1 ? wdata1 : wdata0) : '0;
        mem_wstrb = mem_valid ? (b1 ? strb1 : strb0) : '0;
        done      = !rst && state == FIN;
        err       = done && err_q;
    end
endmodule

// File: tb/tb_store_align_unit.sv
// tb_store_align_unit: directed table-driven check of store_align_unit in split and reject modes.
module tb_store_align_unit;
    logic        clk = 0, rst = 1, req_valid = 0, mem_ready = 0;
    logic [31:0] req_addr = 0, req_data = 0;
    logic [1:0]  req_size = 0;
    logic        req_ready, mem_valid, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        r1_ready, r1_valid, r1_done, r1_err;
    logic [31:0] r1_addr, r1_wdata;
    logic [3:0]  r1_wstrb;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    store_align_unit #(.MISALIGN_SPLIT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .done(done), .err(err)
    );
    store_align_unit #(.MISALIGN_SPLIT(0)) dut_rej (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r1_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(r1_valid), .mem_ready(mem_ready), .mem_addr(r1_addr),
        .mem_wdata(r1_wdata), .mem_wstrb(r1_wstrb), .done(r1_done), .err(r1_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        int          nb;
        logic [31:0] a0;
        logic [31:0] w0;
        logic [3:0]  s0;
        logic [31:0] a1;
        logic [31:0] w1;
        logic [3:0]  s1;
        logic        e;
    } vec_t;
    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic beat(input string nm, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        chk({nm, " valid"}, {31'b0, mem_valid}, 1);
        chk({nm, " addr"}, mem_addr, a);
        chk({nm, " wdata"}, mem_wdata, w);
        chk({nm, " wstrb"}, {28'b0, mem_wstrb}, {28'b0, s});
        chk({nm, " done"}, {31'b0, done}, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        mem_ready = 1;
        chk({t, " req_ready"}, {31'b0, req_ready}, 1);
        req_valid = 1; req_addr = v.addr; req_data = v.data; req_size = v.size;
        step();
        req_valid = 0;
        if (v.nb == 1) begin
            chk({t, " rej valid"}, {31'b0, r1_valid}, 1);
            chk({t, " rej wstrb"}, {28'b0, r1_wstrb}, {28'b0, v.s0});
        end else begin
            chk({t, " rej done"}, {31'b0, r1_done}, 1);
            chk({t, " rej err"}, {31'b0, r1_err}, 1);
            chk({t, " rej valid"}, {31'b0, r1_valid}, 0);
        end
        if (v.nb >= 1) begin
            beat({t, " b0"}, v.a0, v.w0, v.s0);
            step();
        end
        if (v.nb == 2) begin
            beat({t, " b1"}, v.a1, v.w1, v.s1);
            step();
        end
        chk({t, " done"}, {31'b0, done}, 1);
        chk({t, " err"}, {31'b0, err}, {31'b0, v.e});
        chk({t, " fin valid"}, {31'b0, mem_valid}, 0);
        chk({t, " fin wstrb"}, {28'b0, mem_wstrb}, 0);
        chk({t, " fin wdata"}, mem_wdata, 0);
        step();
        chk({t, " done drop"}, {31'b0, done}, 0);
        chk({t, " err drop"}, {31'b0, err}, 0);
    endtask

    initial begin
        vecs[0] = '{32'h00001000, 32'hDEADBEEF, 2'b10, 1, 32'h00001000, 32'hDEADBEEF, 4'hF, 32'h0, 32'h0, 4'h0, 1'b0};
        vecs[1] = '{32'h00000003, 32'h123456A5, 2'b00, 1, 32'h00000000, 32'hA5000000, 4'h8, 32'h0, 32'h0, 4'h0, 1'b0};
        vecs[2] = '{32'h00000006, 32'h11223344, 2'b10, 2, 32'h00000004, 32'h33440000, 4'hC, 32'h00000008, 32'h00001122, 4'h3, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'h0000BEEF, 2'b01, 2, 32'hFFFFFFFC, 32'hEF000000, 4'h8, 32'h00000000, 32'h000000BE, 4'h1, 1'b0};
        vecs[4] = '{32'h00000101, 32'hFFFFCAFE, 2'b01, 1, 32'h00000100, 32'h00CAFE00, 4'h6, 32'h0, 32'h0, 4'h0, 1'b0};
        vecs[5] = '{32'h00000002, 32'hFFFFFF5A, 2'b00, 1, 32'h00000000, 32'h005A0000, 4'h4, 32'h0, 32'h0, 4'h0, 1'b0};
        vecs[6] = '{32'h00000010, 32'h99999999, 2'b11, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b1};
        vecs[7] = '{32'h00000002, 32'h0000ABCD, 2'b01, 1, 32'h00000000, 32'hABCD0000, 4'hC, 32'h0, 32'h0, 4'h0, 1'b0};
        vecs[8] = '{32'h00000003, 32'hAABBCCDD, 2'b10, 2, 32'h00000000, 32'hDD000000, 4'h8, 32'h00000004, 32'h00AABBCC, 4'h7, 1'b0};

        step();
        step();
        chk("rst req_ready", {31'b0, req_ready}, 0);
        chk("rst valid", {31'b0, mem_valid}, 0);
        chk("rst done", {31'b0, done}, 0);
        chk("rst wstrb", {28'b0, mem_wstrb}, 0);
        rst = 0;
        #0;
        chk("post rst ready", {31'b0, req_ready}, 1);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // stall: beat held for three cycles of mem_ready = 0
        mem_ready = 0;
        req_valid = 1; req_addr = 32'h00000020; req_data = 32'hCAFEF00D; req_size = 2'b10;
        step();
        req_valid = 0;
        for (int c = 0; c < 3; c++) begin
            beat($sformatf("stall%0d", c), 32'h00000020, 32'hCAFEF00D, 4'hF);
            chk("stall ready", {31'b0, req_ready}, 0);
            step();
        end
        mem_ready = 1;
        beat("stall3", 32'h00000020, 32'hCAFEF00D, 4'hF);
        step();
        chk("stall done", {31'b0, done}, 1);
        chk("stall err", {31'b0, err}, 0);
        step();
        req_valid = 1; req_addr = 32'h00000040; req_data = 32'h1; req_size = 2'b11;
        step();
        req_valid = 0;
        chk("ill done", {31'b0, done}, 1);
        chk("ill err", {31'b0, err}, 1);
        chk("ill valid", {31'b0, mem_valid}, 0);
        step();

        // reset during beat 1 of a split store
        req_valid = 1; req_addr = 32'h00000006; req_data = 32'h11223344; req_size = 2'b10;
        step();
        req_valid = 0;
        beat("rb b0", 32'h00000004, 32'h33440000, 4'hC);
        step();
        beat("rb b1", 32'h00000008, 32'h00001122, 4'h3);
        rst = 1;
        step();
        rst = 0;
        #0;
        chk("rb valid", {31'b0, mem_valid}, 0);
        chk("rb done", {31'b0, done}, 0);
        step();
        chk("rb valid2", {31'b0, mem_valid}, 0);
        chk("rb done2", {31'b0, done}, 0);
        run_vec(vecs[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
